// File: rtl/comp_8bit_search_if.sv
// Comparator-side bundle of the binary-search controller: start request,
// comparator flags in, probe and search outcome out.
interface comp_8bit_search_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             start;
  logic             a_gt_b;
  logic             a_eq_b;
  logic             a_lt_b;
  logic [WIDTH-1:0] probe;
  logic             busy;
  logic             done;
  logic             found;
  logic [WIDTH-1:0] result;
  logic [CNT_W-1:0] probe_count;
  logic             err;

  modport master (
    input  start, a_gt_b, a_eq_b, a_lt_b,
    output probe, busy, done, found, result, probe_count, err
  );

  modport slave (
    output start, a_gt_b, a_eq_b, a_lt_b,
    input  probe, busy, done, found, result, probe_count, err
  );
endinterface

// File: rtl/comp_8bit_search.sv
// Binary-search controller recovering a value visible only through a magnitude
// comparator. Define COMP_8BIT_SEARCH_ERR_EN to abort on non-one-hot flags.
module comp_8bit_search #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  comp_8bit_search_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MAX_V  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_V  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT1_V = {{(CNT_W-1){1'b0}}, 1'b1};

  // Midpoint with a WIDTH+1-bit sum so lo+hi never wraps.
  function automatic logic [WIDTH-1:0] mid_f(input logic [WIDTH-1:0] lo,
                                             input logic [WIDTH-1:0] hi);
    logic [WIDTH:0] sum;
    sum = {1'b0, lo} + {1'b0, hi};
    return sum[WIDTH:1];
  endfunction

  function automatic logic onehot3_f(input logic [2:0] f);
    case (f)
      3'b001, 3'b010, 3'b100: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_lo, r_hi, r_probe, r_result;
  logic [WIDTH-1:0] w_lo_nxt, w_hi_nxt, w_probe_nxt, w_result_nxt;
  logic [WIDTH-1:0] w_lo_cand, w_hi_cand;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic             r_busy, r_done, r_found, r_err;
  logic             w_busy_nxt, w_done_nxt, w_found_nxt, w_err_nxt;
  logic             w_flag_bad, w_hit, w_step, w_end;

`ifdef COMP_8BIT_SEARCH_ERR_EN
  assign w_flag_bad = ~onehot3_f({bus.a_gt_b, bus.a_eq_b, bus.a_lt_b});
`else
  // Without the check, eq wins over gt and anything else falls to lt.
  assign w_flag_bad = 1'b0;
`endif

  // Next-state, search-window and output computation.
  always_comb begin
    w_state_nxt  = r_state;
    w_lo_nxt     = r_lo;
    w_hi_nxt     = r_hi;
    w_probe_nxt  = r_probe;
    w_result_nxt = r_result;
    w_count_nxt  = r_count;
    w_found_nxt  = r_found;
    w_err_nxt    = r_err;
    w_busy_nxt   = 1'b0;
    w_done_nxt   = 1'b0;
    w_lo_cand    = r_lo;
    w_hi_cand    = r_hi;
    w_hit        = 1'b0;
    w_step       = 1'b0;
    w_end        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_lo_nxt     = ZERO_V;
          w_hi_nxt     = MAX_V;
          w_probe_nxt  = mid_f(ZERO_V, MAX_V);
          w_count_nxt  = CNT1_V;
          w_found_nxt  = 1'b0;
          w_result_nxt = ZERO_V;
          w_err_nxt    = 1'b0;
          w_busy_nxt   = 1'b1;
          w_state_nxt  = S_SEARCH;
        end else begin
          w_state_nxt  = S_IDLE;
        end
      end
      S_SEARCH: begin
        if (w_flag_bad) begin
          w_err_nxt = 1'b1;
          w_end     = 1'b1;
        end else if (bus.a_eq_b) begin
          w_hit = 1'b1;
          w_end = 1'b1;
        end else if (bus.a_gt_b) begin
          if (r_probe == MAX_V) begin
            w_end = 1'b1;
          end else begin
            w_lo_cand = r_probe + ONE_V;
            w_step    = 1'b1;
          end
        end else begin
          if (r_probe == ZERO_V) begin
            w_end = 1'b1;
          end else begin
            w_hi_cand = r_probe - ONE_V;
            w_step    = 1'b1;
          end
        end
        // An emptied window ends the search as a miss.
        if (w_step && (w_lo_cand > w_hi_cand)) begin
          w_end = 1'b1;
        end else begin
          w_end = w_end;
        end
        if (w_end) begin
          w_found_nxt  = w_hit;
          w_result_nxt = w_hit ? r_probe : ZERO_V;
          w_done_nxt   = 1'b1;
          w_state_nxt  = S_DONE;
        end else if (w_step) begin
          w_lo_nxt    = w_lo_cand;
          w_hi_nxt    = w_hi_cand;
          w_probe_nxt = mid_f(w_lo_cand, w_hi_cand);
          w_count_nxt = r_count + CNT1_V;
          w_busy_nxt  = 1'b1;
        end else begin
          w_busy_nxt  = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_lo     <= ZERO_V;
      r_hi     <= ZERO_V;
      r_probe  <= ZERO_V;
      r_result <= ZERO_V;
      r_count  <= {CNT_W{1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_found  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_lo     <= w_lo_nxt;
      r_hi     <= w_hi_nxt;
      r_probe  <= w_probe_nxt;
      r_result <= w_result_nxt;
      r_count  <= w_count_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_found  <= w_found_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign bus.probe       = r_probe;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.found       = r_found;
  assign bus.result      = r_result;
  assign bus.probe_count = r_count;
  assign bus.err         = r_err;

endmodule

// File: tb/tb_comp_8bit_search.sv
// Scoreboard bench for comp_8bit_search: a behavioural binary-search model
// queues expected probes and outcomes; the comparator is modelled on the TB side.
module tb_comp_8bit_search;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
`ifdef COMP_8BIT_SEARCH_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    int found;
    int result;
    int count;
    int err;
    int last_probe;
  } outcome_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  comp_8bit_search_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
  comp_8bit_search #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int tgt      = 0;
  int mode     = 0;   // 0 ideal, 1 stuck gt, 2 no flags on 2nd probe
  int cur_idx  = 0;
  int exp_probe_q[$];
  outcome_t exp_out_q[$];
  logic [2:0] flags_s;

  // Comparator model: a = target, b = DUT probe.
  always_comb begin
    flags_s = 3'b000;
    if (mode == 1) flags_s = 3'b100;
    else if (mode == 2 && cur_idx == 2) flags_s = 3'b000;
    else if (tgt > int'(bus.probe)) flags_s = 3'b100;
    else if (tgt == int'(bus.probe)) flags_s = 3'b010;
    else flags_s = 3'b001;
  end
  assign bus.a_gt_b = flags_s[2];
  assign bus.a_eq_b = flags_s[1];
  assign bus.a_lt_b = flags_s[0];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_search(input int t, input int m);
    int lo = 0, hi = 255, p = 0, cnt = 0;
    bit g, e, l, fin = 0;
    outcome_t o = '{found: 0, result: 0, count: 0, err: 0, last_probe: 0};
    while (!fin && cnt < 16) begin
      p = (lo + hi) / 2;
      cnt++;
      exp_probe_q.push_back(p);
      if (m == 1) begin g = 1; e = 0; l = 0; end
      else if (m == 2 && cnt == 2) begin g = 0; e = 0; l = 0; end
      else begin g = (t > p); e = (t == p); l = (t < p); end
      if (ERR_EN && (int'(g) + int'(e) + int'(l)) != 1) begin
        o.err = 1; fin = 1;
      end else if (e) begin
        o.found = 1; o.result = p; fin = 1;
      end else begin
        if (g) lo = p + 1; else hi = p - 1;
        if (lo > hi) fin = 1;
      end
    end
    o.count = cnt;
    o.last_probe = p;
    exp_out_q.push_back(o);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_probe"}, bus.probe, 0);
    check_val({tag, "_busy"}, bus.busy, 0);
    check_val({tag, "_done"}, bus.done, 0);
    check_val({tag, "_found"}, bus.found, 0);
    check_val({tag, "_result"}, bus.result, 0);
    check_val({tag, "_count"}, bus.probe_count, 0);
    check_val({tag, "_err"}, bus.err, 0);
  endtask

  // abort_at > 0 pulls rst_n low while that probe number is presented.
  task automatic run_search(input int t, input int m, input bit hold_start, input int abort_at);
    int k = 0;
    bit seen = 0;
    outcome_t o;
    @(negedge clk);
    tgt = t; mode = m; cur_idx = 0;
    model_search(t, m);
    bus.start = 1'b1;
    @(negedge clk);
    if (!hold_start) bus.start = 1'b0;
    while (!seen && k < 40) begin
      if (bus.done === 1'b1) begin
        seen = 1;
        bus.start = 1'b0;
        o = exp_out_q.pop_front();
        check_val("latency", k, o.count);
        check_val("found", bus.found, o.found);
        check_val("result", bus.result, o.result);
        check_val("probe_count", bus.probe_count, o.count);
        check_val("err", bus.err, o.err);
        check_val("busy_in_done", bus.busy, 0);
        check_val("probe_hold", bus.probe, o.last_probe);
        check_val("probes_left", exp_probe_q.size(), 0);
        @(negedge clk);
        check_val("done_pulse_end", bus.done, 0);
        check_val("idle_busy", bus.busy, 0);
        check_val("found_held", bus.found, o.found);
        check_val("count_held", bus.probe_count, o.count);
      end else begin
        check_val("busy", bus.busy, 1);
        if (exp_probe_q.size() == 0) check_val("extra_probe", bus.probe, 999);
        else check_val("probe", bus.probe, exp_probe_q.pop_front());
        cur_idx = k + 1;
        if (abort_at > 0 && cur_idx == abort_at) begin
          rst_n = 1'b0;
          #1;
          check_all_zero("async_rst");
          exp_probe_q.delete();
          exp_out_q.delete();
          for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("rst_no_done", bus.done, 0);
          end
          rst_n = 1'b1;
          bus.start = 1'b0;
          return;
        end
        @(negedge clk);
        k++;
      end
    end
    if (!seen) check_val("done_timeout", 0, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_val("idle_no_done", bus.done, 0);
    run_search(127, 0, 1'b0, 0);
    run_search(0, 0, 1'b0, 0);
    run_search(255, 0, 1'b1, 0);   // start held high through the search
    run_search(1, 0, 1'b0, 0);
    run_search(86, 0, 1'b0, 0);
    run_search(0, 1, 1'b0, 0);     // stuck gt
    run_search(200, 0, 1'b0, 4);   // reset on the 4th probe
    run_search(200, 0, 1'b0, 0);
    run_search(200, 2, 1'b0, 0);   // no flags on the 2nd probe
    run_search(43, 0, 1'b0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
endmodule
